// File: rtl/port_uart_tx.sv
// Port-attached 8N1 UART transmitter: rising edges on a strobe push bytes into a
// small FIFO, and a serialiser drains that FIFO onto txd with no idle gap between queued frames.
module port_uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] port_data,
  input  logic       port_strobe,
  input  logic       overflow_clr,
  output logic       txd,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int              BAUD_LAST_I = CLK_DIV - 1;
  localparam logic [15:0]     BAUD_LAST   = BAUD_LAST_I[15:0];
  localparam int              DEPTH_I     = FIFO_DEPTH;
  localparam logic [PTR_W:0]  DEPTH_C     = DEPTH_I[PTR_W:0];
  localparam logic [PTR_W:0]  CNT_ONE     = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             strobe_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic push_req;
  logic push_ok;
  logic pop;
  logic baud_done;

  // Fullness uses the count at the start of the cycle, so a same-cycle pop never rescues a push.
  always_comb begin
    push_req  = port_strobe && !strobe_q;
    push_ok   = push_req && (count_q != DEPTH_C);
    baud_done = (baud_q == BAUD_LAST);

    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
          txd_d   = 1'b0;
          baud_d  = '0;
          shift_d = mem_q[rd_ptr_q];
        end
      end
      START: begin
        if (baud_done) begin
          state_d = DATA;
          bit_d   = '0;
          baud_d  = '0;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // A waiting byte starts its start bit right away so frames stay contiguous.
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = START;
            txd_d   = 1'b0;
            shift_d = mem_q[rd_ptr_q];
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (push_req && !push_ok) overflow_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      strobe_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      strobe_q   <= port_strobe;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push_ok) mem_q[wr_ptr_q] <= port_data;
    end
  end

  assign txd        = txd_q;
  assign tx_busy    = (state_q != IDLE);
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx: a line decoder rebuilds bytes from txd, and each test task
// compares that against bytes predicted from the FIFO/overflow rules.
module tb_port_uart_tx;

  localparam int CD    = 4;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] portData = 8'h00;
  logic       portStrobe = 1'b0;
  logic       overflowClr = 1'b0;
  logic       txd, txBusy, fifoFull, fifoEmpty, overflow;

  int assertCount = 0;
  int failCount = 0;
  int cycleCount = 0;
  int busyCount = 0;
  int framingErr = 0;
  logic [7:0] rxQ[$];
  int startTimes[$];

  port_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH), .PTR_W(2)) dut (
    .clock(clock), .reset(reset), .port_data(portData), .port_strobe(portStrobe),
    .overflow_clr(overflowClr), .txd(txd), .tx_busy(txBusy), .fifo_full(fifoFull),
    .fifo_empty(fifoEmpty), .overflow(overflow)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cycleCount++;
  end

  initial forever begin
    @(negedge clock);
    if (txBusy === 1'b1) busyCount++;
  end

  // Line decoder: finds a start bit, samples mid-bit, and queues each completed byte.
  initial begin
    bit monActive;
    int monCyc;
    logic [7:0] monByte;
    monActive = 0;
    monCyc = 0;
    monByte = 8'h00;
    forever begin
      @(negedge clock);
      if (reset) begin
        monActive = 0;
      end else begin
        if (!monActive) begin
          if (txd === 1'b0) begin
            monActive = 1;
            monCyc = 0;
            startTimes.push_back(cycleCount);
          end
        end else begin
          monCyc++;
        end
        if (monActive && (monCyc % CD) == CD / 2) begin
          if (monCyc / CD == 0) begin
            if (txd !== 1'b0) framingErr++;
          end else if (monCyc / CD <= 8) begin
            monByte[monCyc / CD - 1] = txd;
          end else begin
            if (txd !== 1'b1) framingErr++;
            rxQ.push_back(monByte);
          end
        end
        if (monActive && monCyc == 10 * CD - 1) monActive = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushByte(input logic [7:0] d, input logic clr);
    @(posedge clock);
    #1;
    portData = d;
    portStrobe = 1'b1;
    overflowClr = clr;
    @(posedge clock);
    #1;
    portStrobe = 1'b0;
    overflowClr = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles, output bit ok);
    ok = 0;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clock);
      if (txBusy === 1'b0 && fifoEmpty === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    #1;
    assertCount++;
    if ({txd, txBusy, fifoFull, fifoEmpty, overflow} !== 5'b10010) begin
      failCount++;
      $display("[TB] FAIL reset_values: got txd/busy/full/empty/ovf=%b required 10010",
               {txd, txBusy, fifoFull, fifoEmpty, overflow});
    end
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      assertCount++;
      if ({txd, txBusy, fifoEmpty, overflow} !== 4'b1010) begin
        failCount++;
        $display("[TB] FAIL idle_after_reset: cycle %0d got txd/busy/empty/ovf=%b required 1010",
                 i, {txd, txBusy, fifoEmpty, overflow});
      end
    end
  endtask

  task automatic test_single_byte(input logic [7:0] d);
    logic [9:0] frame;
    bit lineOk;
    frame = {1'b1, d, 1'b0};
    rxQ.delete();
    pushByte(d, 1'b0);
    @(negedge clock);
    assertCount++;
    if (txd !== 1'b1 || fifoEmpty !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL single_latency: got txd=%b empty=%b required txd=1 empty=0", txd, fifoEmpty);
    end
    lineOk = 1;
    for (int k = 0; k < 10 * CD; k++) begin
      @(negedge clock);
      assertCount++;
      if (txd !== frame[k / CD] || txBusy !== 1'b1) begin
        failCount++;
        lineOk = 0;
        $display("[TB] FAIL single_wave: byte %h cycle %0d got txd=%b busy=%b required txd=%b busy=1",
                 d, k, txd, txBusy, frame[k / CD]);
      end
    end
    @(negedge clock);
    assertCount++;
    if (txBusy !== 1'b0 || txd !== 1'b1 || fifoEmpty !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL single_end: got busy=%b txd=%b empty=%b required 0 1 1", txBusy, txd, fifoEmpty);
    end
    assertCount++;
    if (rxQ.size() != 1 || (rxQ.size() == 1 && rxQ[0] !== d)) begin
      failCount++;
      $display("[TB] FAIL single_rx: got %0d bytes first=%h required 1 byte %h",
               rxQ.size(), (rxQ.size() > 0) ? rxQ[0] : 8'h00, d);
    end
    if (lineOk) $display("[TB] single byte %h done", d);
  endtask

  task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b);
    bit ok;
    rxQ.delete();
    startTimes.delete();
    framingErr = 0;
    busyCount = 0;
    pushByte(a, 1'b0);
    pushByte(b, 1'b0);
    waitIdle(300, ok);
    assertCount++;
    if (!ok) begin
      failCount++;
      $display("[TB] FAIL b2b_timeout: got still busy required idle within 300 cycles");
    end
    assertCount++;
    if (busyCount != 20 * CD) begin
      failCount++;
      $display("[TB] FAIL b2b_busy_cycles: got %0d required %0d", busyCount, 20 * CD);
    end
    assertCount++;
    if (rxQ.size() != 2 || rxQ[0] !== a || rxQ[1] !== b) begin
      failCount++;
      $display("[TB] FAIL b2b_data: got %0d bytes required %h %h", rxQ.size(), a, b);
    end
    assertCount++;
    if (startTimes.size() != 2 || (startTimes[1] - startTimes[0]) != 10 * CD) begin
      failCount++;
      $display("[TB] FAIL b2b_gap: got %0d starts required 2 starts %0d cycles apart",
               startTimes.size(), 10 * CD);
    end
    assertCount++;
    if (framingErr != 0) begin
      failCount++;
      $display("[TB] FAIL b2b_framing: got %0d framing errors required 0", framingErr);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] expQ[$];
    logic [7:0] waitQ[$];
    bit inFlight;
    bit ovfExp;
    bit ok;
    logic [7:0] d;
    logic clr;
    for (int round = 0; round < 2; round++) begin
      rxQ.delete();
      expQ.delete();
      waitQ.delete();
      inFlight = 0;
      ovfExp = 0;
      for (int i = 0; i < 6; i++) begin
        d = (round == 0) ? 8'(i + 1) : 8'($urandom_range(0, 255));
        clr = (round == 1 && i == 5);
        pushByte(d, clr);
        if (!inFlight) begin
          inFlight = 1;
          expQ.push_back(d);
        end else if (waitQ.size() < DEPTH) begin
          waitQ.push_back(d);
        end else begin
          ovfExp = 1;
        end
        if (clr && waitQ.size() < DEPTH) ovfExp = 0;
        @(negedge clock);
        assertCount++;
        if (overflow !== ovfExp || fifoFull !== (waitQ.size() == DEPTH)) begin
          failCount++;
          $display("[TB] FAIL ovf_flags: round %0d push %0d got ovf=%b full=%b required ovf=%b full=%b",
                   round, i, overflow, fifoFull, ovfExp, (waitQ.size() == DEPTH));
        end
      end
      foreach (waitQ[j]) expQ.push_back(waitQ[j]);
      waitIdle(400, ok);
      assertCount++;
      if (!ok) begin
        failCount++;
        $display("[TB] FAIL ovf_timeout: got still busy required idle within 400 cycles");
      end
      assertCount++;
      if (rxQ.size() != expQ.size()) begin
        failCount++;
        $display("[TB] FAIL ovf_count: got %0d frames required %0d", rxQ.size(), expQ.size());
      end
      for (int j = 0; j < expQ.size(); j++) begin
        assertCount++;
        if (j >= rxQ.size() || rxQ[j] !== expQ[j]) begin
          failCount++;
          $display("[TB] FAIL ovf_data: frame %0d got %h required %h",
                   j, (j < rxQ.size()) ? rxQ[j] : 8'h00, expQ[j]);
        end
      end
      assertCount++;
      if (overflow !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL ovf_sticky: got %b required 1", overflow);
      end
      @(posedge clock);
      #1;
      overflowClr = 1'b1;
      @(posedge clock);
      #1;
      overflowClr = 1'b0;
      @(negedge clock);
      assertCount++;
      if (overflow !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL ovf_clear: got %b required 0", overflow);
      end
    end
  endtask

  task automatic test_held_strobe();
    bit ok;
    rxQ.delete();
    @(posedge clock);
    #1;
    portData = 8'h3C;
    portStrobe = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      portData = 8'($urandom_range(0, 255));
    end
    portStrobe = 1'b0;
    waitIdle(300, ok);
    repeat (20) @(negedge clock);
    assertCount++;
    if (!ok) begin
      failCount++;
      $display("[TB] FAIL held_timeout: got still busy required idle within 300 cycles");
    end
    assertCount++;
    if (rxQ.size() != 1 || rxQ[0] !== 8'h3C) begin
      failCount++;
      $display("[TB] FAIL held_frames: got %0d frames first=%h required 1 frame 3c",
               rxQ.size(), (rxQ.size() > 0) ? rxQ[0] : 8'h00);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit quiet;
    pushByte(8'h55, 1'b0);
    pushByte(8'($urandom_range(0, 255)), 1'b0);
    pushByte(8'($urandom_range(0, 255)), 1'b0);
    repeat (14) @(posedge clock);
    #3;
    assertCount++;
    if (txd !== 1'b0 || fifoEmpty !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midframe_pre: got txd=%b empty=%b required txd=0 empty=0", txd, fifoEmpty);
    end
    reset = 1'b1;
    #1;
    assertCount++;
    if (txd !== 1'b1 || txBusy !== 1'b0 || fifoEmpty !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL midframe_async: got txd=%b busy=%b empty=%b required 1 0 1", txd, txBusy, fifoEmpty);
    end
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    rxQ.delete();
    quiet = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (txd !== 1'b1 || txBusy !== 1'b0 || fifoEmpty !== 1'b1) quiet = 0;
    end
    assertCount++;
    if (!quiet || rxQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL midframe_after: got quiet=%b frames=%0d required quiet=1 frames=0", quiet, rxQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_byte(8'hA5);
    test_single_byte(8'($urandom_range(0, 255)));
    test_single_byte(8'($urandom_range(0, 255)));
    test_back_to_back(8'h00, 8'hFF);
    test_back_to_back(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    test_overflow();
    test_held_strobe();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/port_uart_tx.md
Name: port_uart_tx

Overview:
- Serial transmit peripheral hung off the 8-bit microcontroller's general-purpose ports; it consumes the bytes the core writes out.
- Firmware drives a byte on portb and toggles a strobe bit on portc[0]; each rising strobe edge pushes that byte into a small FIFO.
- An 8N1 UART serialiser drains the FIFO onto txd.
- Status outputs (fifo_full, tx_busy, overflow) are wired back to portc input bits so firmware can poll them.

Parameters:
- CLK_DIV, 16, clock cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- PTR_W, 2, pointer width; must equal log2(FIFO_DEPTH).

Ports:
- clock  in  1  system clock, same clock as the core.
- reset  in  1  asynchronous, active-high reset.
- port_data  in  8  byte from the core's portb output.
- port_strobe  in  1  write strobe from portc[0]; synchronous to clock.
- overflow_clr  in  1  synchronous clear of the overflow flag.
- txd  out  1  serial output, idles high.
- tx_busy  out  1  high while a frame is in progress.
- fifo_full  out  1  count == FIFO_DEPTH.
- fifo_empty  out  1  count == 0.
- overflow  out  1  sticky flag: a byte was dropped.

Behaviour:
- Clock and reset: one clock, "clock"; reset is asynchronous and active-high. All flops clear immediately on assertion of reset, independent of clock.
- Reset values: txd=1, tx_busy=0, fifo_full=0, fifo_empty=1, overflow=0. Internal state: FSM=IDLE, pointers=0, count=0, strobe_d=0, baud counter=0, bit index=0.
- Reset mid-frame: the frame is aborted, txd returns to 1 at once, and FIFO contents are discarded.
- Strobe edge: strobe_d registers port_strobe every cycle. A push request is port_strobe=1 && strobe_d=0. A strobe held high gives exactly one push.
- Push:
  - If count < FIFO_DEPTH, port_data is written at wr_ptr on that clock edge and wr_ptr increments modulo FIFO_DEPTH.
  - Fullness is judged on count at the start of the cycle. A push when count == FIFO_DEPTH is dropped and sets overflow, even if a pop happens in the same cycle.
- Overflow flag:
  - overflow stays set until overflow_clr=1.
  - If a drop and overflow_clr coincide, the set wins.
- Pop: occurs only when the FSM loads a new byte, i.e. in IDLE with count>0, or at the end of STOP with count>0.
  - The FSM loads mem[rd_ptr] into the shift register and rd_ptr increments.
- Count arithmetic:
  - Simultaneous push and pop leave count unchanged.
  - A push into an empty FIFO cannot be popped in the same cycle; it is popped on the next edge.
- FSM states and transitions (a baud counter counts CLK_DIV cycles per bit):
  - IDLE: txd=1. If count>0: pop, go to START.
  - START: txd=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for CLK_DIV cycles per bit, LSB first. Shift right after each bit. After bit 7 go to STOP.
  - STOP: txd=1 for CLK_DIV cycles. Then, if count>0, pop and go straight to START (no idle gap); otherwise go to IDLE.
- txd is a registered output.
- tx_busy = (state != IDLE).
- fifo_full and fifo_empty are decoded from registered count.
- Latency: for a strobe sampled high at edge N (push), txd falls at edge N+1 when the FIFO was empty and the FSM idle.
- Frame length: exactly 10*CLK_DIV cycles. Back-to-back frames are contiguous.
- Unaffected data: port_data changing while no push is pending has no effect.

Test Plan:
- Reset then idle: hold reset 3 cycles, release, run 100 cycles -> txd=1, tx_busy=0, fifo_empty=1, overflow=0 throughout.
- Single byte (CLK_DIV=4): port_data=0xA5, one strobe pulse -> txd falls one edge after the push and emits 0,1,0,1,0,0,1,0,1,1, 4 cycles each (40 cycles). tx_busy drops after the stop bit; fifo_empty=1.
- Back-to-back: push 0x00 then 0xFF two cycles apart -> frame 2 starts on the cycle after frame 1's stop bit. Total 80 cycles of busy, no idle gap.
- Overflow (CLK_DIV=4, DEPTH=4): push 0x01..0x06 every 2 cycles -> 0x01 transmits immediately, 0x02..0x05 queued, fifo_full=1, 0x06 dropped, overflow=1. Subsequent frames carry 0x02..0x05 in order. Pulse overflow_clr -> overflow=0.
- Held strobe: port_strobe held high 20 cycles with port_data=0x3C -> exactly one 0x3C frame.
- Reset mid-frame: assert reset during DATA bit 3 of 0x55 with 2 bytes queued -> txd=1 immediately. After release: fifo_empty=1, no further frames.
